// File: rtl/alu_mon_pkg.sv
// Shared types and default sizing for the tinyalu result monitor.
// Optional build switch: ALU_MON_LAT_STATS_EN (latency statistic in the watchdog).
package alu_mon_pkg;

    localparam int unsigned RES_W_DEF   = 16;
    localparam int unsigned BATCH_DEF   = 100;
    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned OP_W        = 3;
    localparam int unsigned LAT_W       = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wd_state_e;

    // No-op commands never produce a done, so they are not tracked.
    function automatic logic is_tracked_op(input logic [OP_W-1:0] op);
        return op != OP_W'(OP_NOP);
    endfunction

endpackage

// File: rtl/alu_mon_watchdog.sv
// Per-command watchdog: flags a tracked command that sees no done within TIMEOUT cycles.
// With ALU_MON_LAT_STATS_EN defined it also keeps the largest start-to-done latency.
module alu_mon_watchdog
    import alu_mon_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            done_i,
`ifdef ALU_MON_LAT_STATS_EN
    output logic [LAT_W-1:0] max_lat_o,
`endif
    output logic            timeout_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    wd_state_e       state_q, state_d;
    logic [WD_W-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            start_trk;

`ifdef ALU_MON_LAT_STATS_EN
    logic [LAT_W-1:0] max_lat_q, max_lat_d;
    int unsigned      lat_now;
    logic [LAT_W-1:0] lat_sat;
`endif

    assign start_trk = start_i && is_tracked_op(op_i);

    // Next-state, counter and sticky flag logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`ifdef ALU_MON_LAT_STATS_EN
        max_lat_d = max_lat_q;
        // cnt_q lags the elapsed cycles by one at the done edge.
        lat_now   = 32'(cnt_q) + 32'd1;
        lat_sat   = (lat_now > 32'd255) ? LAT_W'(255) : LAT_W'(lat_now);
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_trk) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (done_i) begin
`ifdef ALU_MON_LAT_STATS_EN
                    if (lat_sat > max_lat_q) begin
                        max_lat_d = lat_sat;
                    end
`endif
                    cnt_d = '0;
                    if (!start_trk) begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + WD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`ifdef ALU_MON_LAT_STATS_EN
            max_lat_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`ifdef ALU_MON_LAT_STATS_EN
            max_lat_q <= max_lat_d;
`endif
        end
    end

    assign timeout_o = timeout_q;
`ifdef ALU_MON_LAT_STATS_EN
    assign max_lat_o = max_lat_q;
`endif

endmodule

// File: rtl/alu_result_monitor.sv
// Packs BATCH done-qualified ALU results LSB-first into one word behind a valid/ack holding register.
// Optional build switch: ALU_MON_LAT_STATS_EN adds max_lat_o.
module alu_result_monitor
    import alu_mon_pkg::*;
#(
    parameter int unsigned RES_W   = RES_W_DEF,
    parameter int unsigned BATCH   = BATCH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = $clog2(BATCH + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [OP_W-1:0]        op_i,
    input  logic                   done_i,
    input  logic [RES_W-1:0]       result_i,
    output logic [BATCH*RES_W-1:0] batch_data_o,
    output logic                   batch_valid_o,
    input  logic                   batch_ack_i,
    output logic [CNT_W-1:0]       fill_count_o,
    output logic                   overflow_o,
`ifdef ALU_MON_LAT_STATS_EN
    output logic [LAT_W-1:0]       max_lat_o,
`endif
    output logic                   timeout_o
);

    localparam int unsigned BUF_W = BATCH * RES_W;

    logic [BUF_W-1:0] fill_q, fill_d;
    logic [BUF_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             complete;
    int unsigned      wr_base;

    assign complete = done_i && (fill_cnt_q == CNT_W'(BATCH - 1));
    assign wr_base  = 32'(fill_cnt_q) * RES_W;

    // Capture, batch hand-off and overflow detection.
    always_comb begin
        fill_d     = fill_q;
        fill_cnt_d = fill_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;

        if (done_i) begin
            fill_d[wr_base +: RES_W] = result_i;
            fill_cnt_d = complete ? '0 : fill_cnt_q + CNT_W'(1);
        end

        if (valid_q && batch_ack_i) begin
            valid_d = 1'b0;
        end

        // An ack in the completing cycle frees the holding register in time.
        if (complete) begin
            if (!valid_q || batch_ack_i) begin
                data_d  = fill_d;
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fill_q     <= '0;
            data_q     <= '0;
            fill_cnt_q <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            data_q     <= data_d;
            fill_cnt_q <= fill_cnt_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    alu_mon_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .done_i    (done_i),
`ifdef ALU_MON_LAT_STATS_EN
        .max_lat_o (max_lat_o),
`endif
        .timeout_o (timeout_o)
    );

    assign batch_data_o  = data_q;
    assign batch_valid_o = valid_q;
    assign fill_count_o  = fill_cnt_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_alu_result_monitor.sv
// Randomized and directed bench for alu_result_monitor against a cycle-count reference model.
// Honours ALU_MON_LAT_STATS_EN for the optional latency port.
module tb_alu_result_monitor;
    import alu_mon_pkg::*;

    localparam int unsigned RES_W   = 16;
    localparam int unsigned BATCH   = 100;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = $clog2(BATCH + 1);

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic                   start_i;
    logic [OP_W-1:0]        op_i;
    logic                   done_i;
    logic [RES_W-1:0]       result_i;
    logic [BATCH*RES_W-1:0] batch_data_o;
    logic                   batch_valid_o;
    logic                   batch_ack_i;
    logic [CNT_W-1:0]       fill_count_o;
    logic                   overflow_o;
    logic                   timeout_o;
`ifdef ALU_MON_LAT_STATS_EN
    logic [LAT_W-1:0]       max_lat_o;
`endif

    alu_result_monitor #(
        .RES_W   (RES_W),
        .BATCH   (BATCH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .op_i          (op_i),
        .done_i        (done_i),
        .result_i      (result_i),
        .batch_data_o  (batch_data_o),
        .batch_valid_o (batch_valid_o),
        .batch_ack_i   (batch_ack_i),
        .fill_count_o  (fill_count_o),
        .overflow_o    (overflow_o),
`ifdef ALU_MON_LAT_STATS_EN
        .max_lat_o     (max_lat_o),
`endif
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [RES_W-1:0] m_q[$];
    logic [RES_W-1:0] m_data[BATCH];
    logic             m_valid, m_overflow, m_timeout, m_pending;
    int               m_cyc, m_start_cyc, m_maxlat;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [RES_W-1:0] dut_entry(input int k);
        return batch_data_o[k*RES_W +: RES_W];
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < BATCH; k++) m_data[k] = '0;
        m_valid    = 1'b0;
        m_overflow = 1'b0;
        m_timeout  = 1'b0;
        m_pending  = 1'b0;
        m_start_cyc = 0;
        m_maxlat   = 0;
    endtask

    // One clock of behaviour, expressed in results collected and cycles elapsed.
    task automatic model_edge(input logic s, input logic [OP_W-1:0] op, input logic d,
                              input logic [RES_W-1:0] r, input logic a);
        logic complete;
        logic trk;
        int   lat;
        m_cyc++;
        complete = 1'b0;
        if (d) begin
            m_q.push_back(r);
            if (m_q.size() == BATCH) complete = 1'b1;
        end
        if (complete) begin
            if (!m_valid || a) begin
                for (int k = 0; k < BATCH; k++) m_data[k] = m_q[k];
                m_valid = 1'b1;
            end else begin
                m_overflow = 1'b1;
            end
            m_q.delete();
        end else if (a && m_valid) begin
            m_valid = 1'b0;
        end

        trk = s && (op != 3'd0);
        if (m_pending) begin
            if (d) begin
                lat = m_cyc - m_start_cyc;
                if (lat > 255) lat = 255;
                if (lat > m_maxlat) m_maxlat = lat;
                if (trk) m_start_cyc = m_cyc;
                else     m_pending = 1'b0;
            end else if (m_cyc - m_start_cyc == TIMEOUT) begin
                m_timeout = 1'b1;
                m_pending = 1'b0;
            end
        end else if (trk) begin
            m_pending   = 1'b1;
            m_start_cyc = m_cyc;
        end
    endtask

    task automatic compare_all();
        int bad;
        bad = 0;
        for (int k = BATCH - 1; k >= 0; k--) begin
            if (dut_entry(k) !== m_data[k]) bad = k;
        end
        check_eq("valid", 32'(batch_valid_o), 32'(m_valid));
        check_eq("overflow", 32'(overflow_o), 32'(m_overflow));
        check_eq("fill_count", 32'(fill_count_o), 32'(m_q.size()));
        check_eq("timeout", 32'(timeout_o), 32'(m_timeout));
        check_eq($sformatf("data[%0d]", bad), 32'(dut_entry(bad)), 32'(m_data[bad]));
`ifdef ALU_MON_LAT_STATS_EN
        check_eq("max_lat", 32'(max_lat_o), 32'(m_maxlat));
`endif
    endtask

    task automatic step(input logic s, input logic [OP_W-1:0] op, input logic d,
                        input logic [RES_W-1:0] r, input logic a);
        @(negedge clk_i);
        start_i     = s;
        op_i        = op;
        done_i      = d;
        result_i    = r;
        batch_ack_i = a;
        @(posedge clk_i);
        model_edge(s, op, d, r, a);
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        start_i     = 1'b0;
        op_i        = '0;
        done_i      = 1'b0;
        result_i    = '0;
        batch_ack_i = 1'b0;
        reset_i     = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk_i);
        #1;
        compare_all();
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    initial begin
        reset_i     = 1'b1;
        start_i     = 1'b0;
        op_i        = '0;
        done_i      = 1'b0;
        result_i    = '0;
        batch_ack_i = 1'b0;
        m_cyc       = 0;
        model_reset();
        apply_reset();

        // Partial batch discarded by reset.
        for (int k = 0; k < 37; k++) step(1'b0, 3'd0, 1'b1, RES_W'($urandom), 1'b0);
        check_eq("mid_fill37", 32'(fill_count_o), 32'd37);
        apply_reset();
        check_eq("mid_rst_fill", 32'(fill_count_o), 32'd0);
        check_eq("mid_rst_valid", 32'(batch_valid_o), 32'd0);

        // Full batch, then a second one with no ack.
        for (int k = 0; k < BATCH; k++) begin
            step(1'b0, 3'd0, 1'b1, RES_W'(k), 1'b0);
            if (k == BATCH - 2) check_eq("valid_before_last", 32'(batch_valid_o), 32'd0);
        end
        check_eq("full_valid", 32'(batch_valid_o), 32'd1);
        check_eq("full_entry0", 32'(dut_entry(0)), 32'd0);
        check_eq("full_entry99", 32'(dut_entry(BATCH - 1)), 32'd99);
        check_eq("full_fill", 32'(fill_count_o), 32'd0);
        for (int k = 0; k < BATCH; k++) begin
            step(1'b0, 3'd0, 1'b1, RES_W'(BATCH + k), 1'b0);
            if (k == BATCH - 2) check_eq("ovf_before", 32'(overflow_o), 32'd0);
        end
        check_eq("ovf_set", 32'(overflow_o), 32'd1);
        check_eq("ovf_entry0", 32'(dut_entry(0)), 32'd0);
        check_eq("ovf_fill", 32'(fill_count_o), 32'd0);

        // Ack coinciding with the second completion.
        apply_reset();
        for (int k = 0; k < BATCH; k++) step(1'b0, 3'd0, 1'b1, RES_W'(k), 1'b0);
        for (int k = 0; k < BATCH - 1; k++) step(1'b0, 3'd0, 1'b1, RES_W'(BATCH + k), 1'b0);
        step(1'b0, 3'd0, 1'b1, RES_W'(2 * BATCH - 1), 1'b1);
        check_eq("sim_valid", 32'(batch_valid_o), 32'd1);
        check_eq("sim_entry0", 32'(dut_entry(0)), 32'd100);
        check_eq("sim_entry99", 32'(dut_entry(BATCH - 1)), 32'd199);
        check_eq("sim_ovf", 32'(overflow_o), 32'd0);
        step(1'b0, 3'd0, 1'b0, '0, 1'b1);
        check_eq("ack_clears", 32'(batch_valid_o), 32'd0);
        check_eq("ack_keeps_data", 32'(dut_entry(0)), 32'd100);

        // Watchdog: tracked MUL times out, NOP does not.
        apply_reset();
        step(1'b1, 3'(OP_MUL), 1'b0, '0, 1'b0);
        for (int k = 0; k < TIMEOUT - 1; k++) step(1'b0, 3'd0, 1'b0, '0, 1'b0);
        check_eq("to_not_yet", 32'(timeout_o), 32'd0);
        step(1'b0, 3'd0, 1'b0, '0, 1'b0);
        check_eq("to_set", 32'(timeout_o), 32'd1);
        apply_reset();
        step(1'b1, 3'(OP_NOP), 1'b0, '0, 1'b0);
        for (int k = 0; k < TIMEOUT + 4; k++) step(1'b0, 3'd0, 1'b0, '0, 1'b0);
        check_eq("to_nop", 32'(timeout_o), 32'd0);

`ifdef ALU_MON_LAT_STATS_EN
        apply_reset();
        step(1'b1, 3'(OP_MUL), 1'b0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 16'h1234, 1'b0);
        step(1'b1, 3'(OP_ADD), 1'b0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 16'h0042, 1'b0);
        check_eq("lat_max3", 32'(max_lat_o), 32'd3);
`endif

        // Randomized traffic in a few reset-separated phases.
        for (int ph = 0; ph < 4; ph++) begin
            apply_reset();
            for (int c = 0; c < 500; c++) begin
                step(($urandom % 3) == 0, 3'($urandom_range(0, 4)),
                     ($urandom % (ph + 2)) == 0, RES_W'($urandom),
                     ($urandom % (4 + 4 * ph)) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_monitor.md
Name: alu_result_monitor

Overview:
- Downstream stage of the ALU stimulus driver. Watches the tinyalu command/response pins, captures each `result` qualified by `done`, and packs BATCH results LSB-first into one wide word for the Python/cocotb side to read.
- Provides a one-deep output holding register with a valid/ack handshake, a sticky overflow flag, and a per-command timeout watchdog.

Parameters:
- RES_W, 16, width of one ALU result
- BATCH, 100, results per packed batch (matches 100-command stimulus frame)
- TIMEOUT, 16, max cycles from accepted command to `done` before timeout flag
- CNT_W, $clog2(BATCH+1), width of fill counter

Ports:
- clk_i  in  1  system clock, all logic on posedge
- reset_i  in  1  asynchronous active-low reset
- start_i  in  1  ALU start, as driven to tinyalu
- op_i  in  3  ALU opcode, as driven to tinyalu
- done_i  in  1  ALU done
- result_i  in  RES_W  ALU result, valid when done_i=1
- batch_data_o  out  BATCH*RES_W  packed batch, entry k at [k*RES_W +: RES_W]
- batch_valid_o  out  1  batch_data_o holds an unconsumed batch
- batch_ack_i  in  1  consumer accepts batch; effective only while batch_valid_o=1
- fill_count_o  out  CNT_W  results captured in the batch being filled
- overflow_o  out  1  sticky: a completed batch was dropped
- timeout_o  out  1  sticky: a command got no done within TIMEOUT cycles

Behaviour:
- Reset (reset_i=0, async): all outputs 0, fill buffer 0, FSM=IDLE. Reset mid-batch discards partial data.
- Capture: every cycle with done_i=1 writes result_i into fill entry fill_count_o and increments fill_count_o. This is independent of FSM state; done_i is authoritative.
- Batch completion: on capture with fill_count_o==BATCH-1, the next edge does the following.
  - Full buffer, including the current result, transfers to batch_data_o.
  - batch_valid_o=1, fill_count_o=0.
- Handshake:
  - batch_ack_i && batch_valid_o clears batch_valid_o next cycle. batch_data_o holds its value; it is not cleared.
  - Ack while valid=0 is ignored.
- Collision: completion while batch_valid_o=1 and no ack the same cycle.
  - New batch dropped, output unchanged, overflow_o=1 (sticky until reset).
  - fill_count_o still wraps to 0.
- Simultaneous ack + completion: new batch loads, batch_valid_o stays 1, no overflow.
- Watchdog FSM:
  - IDLE: start_i=1 and op_i!=0 -> WAIT, wd counter=0. op_i==0 (no-op) is not tracked.
  - WAIT: done_i=1 -> IDLE, or -> WAIT (counter reset) if start_i=1 and op_i!=0 in the same cycle. Otherwise the counter increments.
  - Counter reaching TIMEOUT -> timeout_o=1 (sticky), FSM -> IDLE.
- Latency: result visible in batch_data_o 1 cycle after the completing done_i edge. No combinational input-to-output paths.

Optional Feature:
- ALU_MON_LAT_STATS_EN
  - Defined: adds port `max_lat_o` (out, 8 bits, saturating at 255), holding the largest observed start-to-done cycle count in WAIT. Reset 0; updated on the done edge.
  - Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package `alu_mon_pkg` holds:
  - opcode enum (NOP=0, ADD=1, AND=2, XOR=3, MUL=4)
  - FSM state typedef (IDLE, WAIT)
  - default RES_W/BATCH/TIMEOUT constants
- One natural sub-module: `alu_mon_watchdog` (FSM + timeout counter + optional latency stat). The top level keeps the packing buffer and handshake.

Test Plan:
- Reset mid-batch: 37 dones, then reset_i low 2 cycles -> fill_count_o=0, all flags 0, batch_valid_o=0.
- Full batch: 100 dones with result_i=k (k=0..99), no ack.
  - batch_valid_o=1 one cycle after the 100th done.
  - batch_data_o[15:0]=0, [1599:1584]=99.
  - fill_count_o=0.
- Overflow: 200 dones, no ack -> overflow_o=1 after the 200th done; batch_data_o still holds the first batch (entry 0 = 0).
- Simultaneous ack: ack asserted on the same cycle the second batch completes (second batch values 100..199) -> batch_valid_o stays 1, batch_data_o[15:0]=100, overflow_o=0.
- Timeout: start_i=1 with op_i=4, done_i held 0 for 16 cycles -> timeout_o=1. Repeat with op_i=0 -> timeout_o stays 0.
- Latency stat (macro on): MUL done 3 cycles after start, ADD done after 1 -> max_lat_o=3.
